// File: rtl/debug_dump_pkg.sv
// Shared definitions for the debug dump capture engine: FSM state codes,
// section codes and a width helper for parameter-derived port sizes.
package debug_dump_pkg;

  localparam int DEF_WORD_BYTES = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PC    = 3'd1;
  localparam logic [2:0] ST_REGS  = 3'd2;
  localparam logic [2:0] ST_MEM   = 3'd3;
  localparam logic [2:0] ST_CHK   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERROR = 3'd6;

  localparam logic [1:0] SEC_PC  = 2'd0;
  localparam logic [1:0] SEC_REG = 2'd1;
  localparam logic [1:0] SEC_MEM = 2'd2;

  // Index width for n entries, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Collects WORD_BYTES bytes LSB-first into one word; o_word_done marks the cycle
// the final byte arrives, with o_word already containing that byte.
module byte_word_assembler
  import debug_dump_pkg::*;
#(
  parameter int WORD_BYTES = DEF_WORD_BYTES
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_clear,
  input  logic                    i_byte_valid,
  input  logic [7:0]              i_byte,
  output logic [8*WORD_BYTES-1:0] o_word,
  output logic                    o_word_done
);

  localparam int CW = width_of(WORD_BYTES);

  logic [CW-1:0]           byte_cnt;
  logic [8*WORD_BYTES-1:0] word_q;

  // NOTE: o_word gets a full default before the lane override, so no latch is inferred.
  always_comb begin
    o_word = word_q;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (byte_cnt == CW'(k)) o_word[8*k +: 8] = i_byte;
    end
    o_word_done = i_byte_valid && (byte_cnt == CW'(WORD_BYTES - 1));
  end

  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      byte_cnt <= '0;
      word_q   <= '0;
    end else if (i_byte_valid) begin
      word_q   <= o_word;
      byte_cnt <= o_word_done ? '0 : byte_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/debug_dump_collector.sv
// Captures a PC/register/memory dump arriving byte-wise from a UART receiver.
// Defining DEBUG_DUMP_CHECKSUM_EN adds a trailing 8-bit checksum byte (CHK state).
module debug_dump_collector
  import debug_dump_pkg::*;
#(
  parameter int  WORD_BYTES     = DEF_WORD_BYTES,
  parameter int  REG_COUNT      = 32,
  parameter int  MEM_COUNT      = 32,
  parameter int  TIMEOUT_CYCLES = 200000,
  localparam int WW             = 8 * WORD_BYTES,
  localparam int DEPTH          = REG_COUNT + MEM_COUNT,
  localparam int AW             = width_of(DEPTH),
  localparam int IW             = width_of((REG_COUNT > MEM_COUNT) ? REG_COUNT : MEM_COUNT)
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_rx_done,
  input  logic [7:0]    i_rx_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [WW-1:0] o_rd_data,
  output logic [WW-1:0] o_pc,
  output logic          o_word_valid,
  output logic [WW-1:0] o_word,
  output logic [1:0]    o_section,
  output logic [IW-1:0] o_index,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_timeout,
  output logic          o_chk_error
);

  localparam int TW = width_of(TIMEOUT_CYCLES);
`ifdef DEBUG_DUMP_CHECKSUM_EN
  localparam logic [2:0] END_ST = ST_CHK;
`else
  localparam logic [2:0] END_ST = ST_DONE;
`endif
  // Empty sections are skipped within the same transition.
  localparam logic [2:0] AFTER_REGS = (MEM_COUNT > 0) ? ST_MEM : END_ST;
  localparam logic [2:0] AFTER_PC   = (REG_COUNT > 0) ? ST_REGS : AFTER_REGS;

  logic [2:0]    state;
  logic [IW-1:0] idx;
  logic [TW-1:0] tmo_cnt;
  logic [WW-1:0] store [DEPTH];
  logic          start_go, byte_take, tmo_fire, word_done;
  logic [WW-1:0] asm_word;

  assign o_busy    = (state == ST_PC) || (state == ST_REGS) || (state == ST_MEM) || (state == ST_CHK);
  assign o_done    = (state == ST_DONE);
  assign o_timeout = (state == ST_ERROR);
  assign start_go  = i_start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
  assign byte_take = i_rx_done && ((state == ST_PC) || (state == ST_REGS) || (state == ST_MEM));
  assign tmo_fire  = (TIMEOUT_CYCLES != 0) && o_busy && !i_rx_done &&
                     (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  byte_word_assembler #(.WORD_BYTES(WORD_BYTES)) u_asm (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_clear      (start_go || tmo_fire),
    .i_byte_valid (byte_take),
    .i_byte       (i_rx_data),
    .o_word       (asm_word),
    .o_word_done  (word_done)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      idx          <= '0;
      tmo_cnt      <= '0;
      o_pc         <= '0;
      o_word_valid <= 1'b0;
      o_word       <= '0;
      o_section    <= SEC_PC;
      o_index      <= '0;
    end else begin
      o_word_valid <= 1'b0;
      if (start_go) begin
        state   <= ST_PC;
        idx     <= '0;
        tmo_cnt <= '0;
      end else if (o_busy) begin
        if (i_rx_done)                tmo_cnt <= '0;
        else if (tmo_fire)            state   <= ST_ERROR;
        else if (TIMEOUT_CYCLES != 0) tmo_cnt <= tmo_cnt + 1'b1;

        if (state == ST_CHK && i_rx_done) state <= ST_DONE;

        if (word_done) begin
          o_word_valid <= 1'b1;
          o_word       <= asm_word;
          o_index      <= idx;
          case (state)
            ST_PC: begin
              o_section <= SEC_PC;
              o_pc      <= asm_word;
              state     <= AFTER_PC;
            end
            ST_REGS: begin
              o_section <= SEC_REG;
              if (idx == IW'(REG_COUNT - 1)) begin
                idx   <= '0;
                state <= AFTER_REGS;
              end else begin
                idx <= idx + 1'b1;
              end
            end
            default: begin
              o_section <= SEC_MEM;
              if (idx == IW'(MEM_COUNT - 1)) begin
                idx   <= '0;
                state <= END_ST;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          endcase
        end
      end
    end
  end

  // NOTE: the capture store has no reset; a location is meaningful only after a dump writes it.
  always_ff @(posedge i_clock) begin
    if (!i_reset && word_done && state == ST_REGS)     store[AW'(idx)]                  <= asm_word;
    else if (!i_reset && word_done && state == ST_MEM) store[AW'(REG_COUNT) + AW'(idx)] <= asm_word;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset)                                        o_rd_data <= '0;
    else if ({1'b0, i_rd_addr} < (AW + 1)'(DEPTH))      o_rd_data <= store[i_rd_addr];
    else                                                o_rd_data <= '0;
  end

`ifdef DEBUG_DUMP_CHECKSUM_EN
  logic [7:0] chk_sum;
  logic       chk_err;

  always_ff @(posedge i_clock) begin
    if (i_reset || start_go) begin
      chk_sum <= '0;
      chk_err <= 1'b0;
    end else if (byte_take) begin
      chk_sum <= chk_sum + i_rx_data;
    end else if (state == ST_CHK && i_rx_done) begin
      chk_err <= (i_rx_data != chk_sum);
    end
  end

  assign o_chk_error = chk_err;
`else
  assign o_chk_error = 1'b0;
`endif

endmodule

// File: tb/tb_debug_dump_collector.sv
// Self-checking bench for debug_dump_collector: a 4-byte/32/32 instance and a
// 2-byte/4/0 instance, driven with random dumps against a word-list model.
module tb_debug_dump_collector;
  import debug_dump_pkg::*;

  localparam int TMO = 64;
  localparam int RC  = 32;
  localparam int MC  = 32;

  typedef struct {
    logic [1:0]  sec;
    int          idx;
    logic [31:0] w;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, rx_done;
  logic [7:0]  rx_data;
  logic [5:0]  rd_addr;
  logic [31:0] rd_data, pc, word;
  logic        word_valid, busy, done, tmo, chk_err;
  logic [1:0]  section;
  logic [4:0]  index;

  logic        start6, rx_done6;
  logic [7:0]  rx_data6;
  logic [1:0]  rd_addr6;
  logic [15:0] rd_data6, pc6, word6;
  logic        wv6, busy6, done6, tmo6, chk6;
  logic [1:0]  sec6, index6;

  debug_dump_collector #(.WORD_BYTES(4), .REG_COUNT(RC), .MEM_COUNT(MC), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_rx_done(rx_done), .i_rx_data(rx_data),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_pc(pc), .o_word_valid(word_valid), .o_word(word),
    .o_section(section), .o_index(index), .o_busy(busy), .o_done(done), .o_timeout(tmo),
    .o_chk_error(chk_err)
  );

  debug_dump_collector #(.WORD_BYTES(2), .REG_COUNT(4), .MEM_COUNT(0), .TIMEOUT_CYCLES(TMO)) dut6 (
    .i_clock(clk), .i_reset(rst), .i_start(start6), .i_rx_done(rx_done6), .i_rx_data(rx_data6),
    .i_rd_addr(rd_addr6), .o_rd_data(rd_data6), .o_pc(pc6), .o_word_valid(wv6), .o_word(word6),
    .o_section(sec6), .o_index(index6), .o_busy(busy6), .o_done(done6), .o_timeout(tmo6),
    .o_chk_error(chk6)
  );

  int          errors = 0;
  int          checks = 0;
  int          pulses = 0;
  int          pulses6 = 0;
  ev_t         exp_q[$];
  ev_t         exp6_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_reg [RC];
  logic [31:0] m_mem [MC];
  logic [7:0]  m_sum;
  bit          want_bad_sum;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word-event monitors: every o_word_valid pulse must match the next modelled word.
  always @(negedge clk) begin
    ev_t e;
    if (word_valid) begin
      pulses++;
      if (exp_q.size() == 0) check("spurious_word_valid", word_valid, 0);
      else begin
        e = exp_q.pop_front();
        check("word", word, e.w);
        check("section", section, e.sec);
        check("index", index, e.idx);
      end
    end
  end

  always @(negedge clk) begin
    ev_t e;
    if (wv6) begin
      pulses6++;
      check("w6_section_not_mem", sec6 == SEC_MEM, 0);
      if (exp6_q.size() == 0) check("w6_spurious_word_valid", wv6, 0);
      else begin
        e = exp6_q.pop_front();
        check("w6_word", word6, e.w);
        check("w6_section", sec6, e.sec);
        check("w6_index", index6, e.idx);
      end
    end
  end

  task automatic send_byte(input bit sel, input logic [7:0] b);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    if (sel) begin rx_done6 = 1'b1; rx_data6 = b; end
    else     begin rx_done  = 1'b1; rx_data  = b; end
    @(negedge clk);
    rx_done  = 1'b0;
    rx_done6 = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // Sends the low nb bytes of w LSB-first; a complete word is queued as an expected event.
  task automatic send_word(input bit sel, input logic [31:0] w, input logic [1:0] sec,
                           input int idx, input int nb, input bit full);
    ev_t e;
    if (full) begin
      e.sec = sec; e.idx = idx; e.w = w;
      if (sel) exp6_q.push_back(e); else exp_q.push_back(e);
    end
    for (int k = 0; k < nb; k++) begin
      m_sum = m_sum + w[8*k +: 8];
      send_byte(sel, w[8*k +: 8]);
    end
  endtask

  task automatic pulse_start(input bit with_byte);
    @(negedge clk);
    start = 1'b1; rx_done = with_byte; rx_data = 8'hEE;
    @(negedge clk);
    start = 1'b0; rx_done = 1'b0;
  endtask

  task automatic read_check(input string tag, input int a, input logic [31:0] exp);
    @(negedge clk);
    rd_addr = 6'(a);
    @(negedge clk);
    check(tag, rd_data, exp);
  endtask

  task automatic randomize_model();
    m_pc = $urandom;
    for (int i = 0; i < RC; i++) m_reg[i] = $urandom;
    for (int i = 0; i < MC; i++) m_mem[i] = $urandom;
  endtask

  task automatic full_dump(input bit with_byte);
    pulses = 0;
    m_sum  = 8'h00;
    pulse_start(with_byte);
    check("state_after_start", {busy, done, tmo}, 3'b100);
    send_word(1'b0, m_pc, SEC_PC, 0, 4, 1'b1);
    for (int i = 0; i < RC; i++) send_word(1'b0, m_reg[i], SEC_REG, i, 4, 1'b1);
    for (int i = 0; i < MC; i++) send_word(1'b0, m_mem[i], SEC_MEM, i, 4, 1'b1);
`ifdef DEBUG_DUMP_CHECKSUM_EN
    check("chk_pending", {busy, done}, 2'b10);
    send_byte(1'b0, want_bad_sum ? 8'(m_sum + 8'd1) : m_sum);
    check("chk_error", chk_err, want_bad_sum);
`else
    check("chk_error_tied", chk_err, 0);
`endif
    check("done_flags", {busy, done, tmo}, 3'b010);
    repeat (2) @(negedge clk);
    check("pulse_count", pulses, 1 + RC + MC);
    check("pc", pc, m_pc);
  endtask

  task automatic verify_store(input string tag);
    for (int i = 0; i < RC; i++) read_check({tag, "_reg"}, i, m_reg[i]);
    for (int i = 0; i < MC; i++) read_check({tag, "_mem"}, RC + i, m_mem[i]);
  endtask

  initial begin
    logic [31:0] old_reg7;
    logic [15:0] p6;
    logic [15:0] r6 [4];

    rst = 1'b1; start = 1'b0; rx_done = 1'b0; rx_data = 8'h00; rd_addr = 6'd0;
    start6 = 1'b0; rx_done6 = 1'b0; rx_data6 = 8'h00; rd_addr6 = 2'd0;
    want_bad_sum = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_flags", {busy, done, tmo, chk_err, word_valid}, 5'b0);
    check("rst_pc", pc, 0);
    check("rst_word", {word, section, index}, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_dut6", {busy6, done6, tmo6, chk6, wv6, pc6, rd_data6}, 0);
    rst = 1'b0;

    // Bytes while idle are dropped.
    pulses = 0;
    repeat (6) send_byte(1'b0, 8'($urandom));
    check("idle_no_pulses", pulses, 0);
    check("idle_not_busy", busy, 0);

    // Reference dump; start arrives together with a byte that must be dropped.
    m_pc = 32'h0000_0024;
    for (int i = 0; i < RC; i++) m_reg[i] = i;
    for (int i = 0; i < MC; i++) m_mem[i] = 32'hA5A5_0000 + i;
    full_dump(1'b1);
    read_check("rd_reg3", 3, 32'h0000_0003);
    read_check("rd_mem5", RC + 5, 32'hA5A5_0005);
    verify_store("t1");

    // Bytes after completion are dropped and leave captured data intact.
    pulses = 0;
    repeat (8) send_byte(1'b0, 8'($urandom));
    check("post_done_no_pulses", pulses, 0);
    check("post_done_flags", {busy, done}, 2'b01);
    check("post_done_pc", pc, m_pc);
    read_check("post_done_reg9", 9, m_reg[9]);
    read_check("post_done_mem31", RC + 31, m_mem[31]);

    // Random dump; with the checksum build the trailer is deliberately wrong.
    randomize_model();
    want_bad_sum = 1'b1;
    full_dump(1'b0);
    want_bad_sum = 1'b0;
    verify_store("t_rand");

    // Inter-byte timeout part way through reg[7].
    old_reg7 = m_reg[7];
    m_pc = $urandom;
    pulses = 0;
    m_sum = 8'h00;
    pulse_start(1'b0);
    send_word(1'b0, m_pc, SEC_PC, 0, 4, 1'b1);
    for (int i = 0; i < 7; i++) begin
      m_reg[i] = $urandom;
      send_word(1'b0, m_reg[i], SEC_REG, i, 4, 1'b1);
    end
    send_word(1'b0, $urandom, SEC_REG, 7, 2, 1'b0);
    repeat (TMO - 2) @(negedge clk);
    check("tmo_not_yet", {busy, tmo}, 2'b10);
    repeat (4) @(negedge clk);
    check("tmo_flags", {busy, done, tmo}, 3'b001);
    check("tmo_pulses", pulses, 8);
    check("tmo_pc", pc, m_pc);
    read_check("tmo_reg6", 6, m_reg[6]);
    read_check("tmo_reg7_kept", 7, old_reg7);

    // Restart from ERROR discards the partial word.
    randomize_model();
    full_dump(1'b0);
    verify_store("t_restart");

    // Reset in the middle of mem[10].
    randomize_model();
    pulses = 0;
    m_sum = 8'h00;
    pulse_start(1'b0);
    send_word(1'b0, m_pc, SEC_PC, 0, 4, 1'b1);
    for (int i = 0; i < RC; i++) send_word(1'b0, m_reg[i], SEC_REG, i, 4, 1'b1);
    for (int i = 0; i < 10; i++) send_word(1'b0, m_mem[i], SEC_MEM, i, 4, 1'b1);
    send_word(1'b0, m_mem[10], SEC_MEM, 10, 2, 1'b0);
    rd_addr = 6'd3;
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_flags", {busy, done, tmo, chk_err, word_valid}, 5'b0);
    check("midrst_pc", pc, 0);
    check("midrst_word", {word, section, index}, 0);
    check("midrst_rd_data", rd_data, 0);
    rst = 1'b0;
    randomize_model();
    full_dump(1'b0);
    verify_store("t_after_rst");

    // Narrow-word instance with no memory section.
    p6 = 16'($urandom);
    pulses6 = 0;
    m_sum = 8'h00;
    @(negedge clk); start6 = 1'b1;
    @(negedge clk); start6 = 1'b0;
    send_word(1'b1, {16'h0, p6}, SEC_PC, 0, 2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      r6[i] = 16'($urandom);
      send_word(1'b1, {16'h0, r6[i]}, SEC_REG, i, 2, 1'b1);
    end
    check("w6_busy_before_last", {busy6, done6}, 2'b10);
    r6[3] = 16'($urandom);
    send_word(1'b1, {16'h0, r6[3]}, SEC_REG, 3, 2, 1'b1);
`ifdef DEBUG_DUMP_CHECKSUM_EN
    check("w6_chk_pending", {busy6, done6}, 2'b10);
    send_byte(1'b1, m_sum);
    check("w6_chk_error", chk6, 0);
`endif
    check("w6_done", {busy6, done6, tmo6}, 3'b010);
    repeat (2) @(negedge clk);
    check("w6_pulses", pulses6, 5);
    check("w6_pc", pc6, p6);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); rd_addr6 = 2'(i);
      @(negedge clk); check("w6_rd_reg", rd_data6, r6[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
